// File: rtl/vx_dcache_req_arb_pkg.sv
// Shared constants and extended-tag helpers for the data-cache request arbiter.
// The DFLT_* values are the default configuration. The helpers use the default
// widths; the parameterised RTL packs and unpacks tags with plain slicing.
package vx_dcache_req_arb_pkg;

  localparam int unsigned DFLT_NUM_REQS    = 4;
  localparam int unsigned DFLT_ADDR_WIDTH  = 32;
  localparam int unsigned DFLT_DATA_SIZE   = 4;
  localparam int unsigned DFLT_TAG_WIDTH   = 8;
  localparam int unsigned DFLT_MAX_PENDING = 16;

  localparam int unsigned IDX_BITS      = $clog2(DFLT_NUM_REQS);
  localparam int unsigned PENDING_BITS  = $clog2(DFLT_MAX_PENDING) + 1;
  localparam int unsigned EXT_TAG_WIDTH = DFLT_TAG_WIDTH + IDX_BITS;

  // Memory-side tag: source tag in the upper bits, channel index in the low bits.
  typedef struct packed {
    logic [DFLT_TAG_WIDTH-1:0] tag;
    logic [IDX_BITS-1:0]       idx;
  } ext_tag_t;

  function automatic ext_tag_t pack_tag(input logic [DFLT_TAG_WIDTH-1:0] tag,
                                        input logic [IDX_BITS-1:0]       idx);
    ext_tag_t t;
    t.tag = tag;
    t.idx = idx;
    return t;
  endfunction

  function automatic logic [IDX_BITS-1:0] tag_idx(input ext_tag_t t);
    return t.idx;
  endfunction

  function automatic logic [DFLT_TAG_WIDTH-1:0] tag_src(input ext_tag_t t);
    return t.tag;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter with an enable.
// Ports: clk, reset (async, active low); req - request vector; en - a grant may
// be issued this cycle; grant_c - one-hot grant; grant_idx_c - granted index;
// grant_vld_c - a grant is issued. The search starts at the channel after the
// last granted one. The pointer holds when nothing is granted.
module vx_rr_arbiter
  import vx_dcache_req_arb_pkg::*;
#(
  parameter int unsigned NUM_REQS = DFLT_NUM_REQS,
  localparam int unsigned IDX_W   = $clog2(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req,
  input  logic                en,
  output logic [NUM_REQS-1:0] grant_c,
  output logic [IDX_W-1:0]    grant_idx_c,
  output logic                grant_vld_c
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // First requester at or after the pointer. The index wraps naturally because
  // NUM_REQS is a power of two.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    cand        = '0;
    ptr_d       = ptr_q;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant_idx_c = cand;
      end
    end
    grant_vld_c = en && found;
    if (grant_vld_c) begin
      grant_c[grant_idx_c] = 1'b1;
      ptr_d                = grant_idx_c + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vx_dcache_req_arb.sv
// Merges NUM_REQS data-cache request channels into one memory request port.
// Ports: clk, reset (async, active low); in_req_* - per-channel requests with
// in_req_ready = grant; in_rsp_* - responses routed back to the source channel
// (data and tag broadcast, valid one-hot); out_req_* - merged, registered
// request with tag {in_tag, idx}; out_rsp_* - memory response input;
// pending_count - outstanding reads; busy - reads pending or output stage full.
module vx_dcache_req_arb
  import vx_dcache_req_arb_pkg::*;
#(
  parameter int unsigned NUM_REQS    = DFLT_NUM_REQS,
  parameter int unsigned ADDR_WIDTH  = DFLT_ADDR_WIDTH,
  parameter int unsigned DATA_SIZE   = DFLT_DATA_SIZE,
  parameter int unsigned TAG_WIDTH   = DFLT_TAG_WIDTH,
  parameter int unsigned MAX_PENDING = DFLT_MAX_PENDING,
  localparam int unsigned IDX_W      = $clog2(NUM_REQS),
  localparam int unsigned DATA_W     = DATA_SIZE * 8,
  localparam int unsigned OTAG_W     = TAG_WIDTH + IDX_W,
  localparam int unsigned PEND_W     = $clog2(MAX_PENDING) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           in_req_valid,
  input  logic [NUM_REQS-1:0]           in_req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] in_req_addr,
  input  logic [NUM_REQS*DATA_SIZE-1:0] in_req_byteen,
  input  logic [NUM_REQS*DATA_W-1:0]    in_req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0] in_req_tag,
  output logic [NUM_REQS-1:0]           in_req_ready,
  output logic [NUM_REQS-1:0]           in_rsp_valid,
  output logic [NUM_REQS*DATA_W-1:0]    in_rsp_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0] in_rsp_tag,
  input  logic [NUM_REQS-1:0]           in_rsp_ready,
  output logic                          out_req_valid,
  output logic                          out_req_rw,
  output logic [ADDR_WIDTH-1:0]         out_req_addr,
  output logic [DATA_SIZE-1:0]          out_req_byteen,
  output logic [DATA_W-1:0]             out_req_data,
  output logic [OTAG_W-1:0]             out_req_tag,
  input  logic                          out_req_ready,
  input  logic                          out_rsp_valid,
  input  logic [DATA_W-1:0]             out_rsp_data,
  input  logic [OTAG_W-1:0]             out_rsp_tag,
  output logic                          out_rsp_ready,
  output logic [PEND_W-1:0]             pending_count,
  output logic                          busy
);

  logic [NUM_REQS-1:0] arb_req, grant;
  logic [IDX_W-1:0]    gidx;
  logic                gvld, stage_ready, pend_full, pend_inc, pend_dec;

  logic                  out_valid_q, out_valid_d;
  logic                  out_rw_q, out_rw_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_SIZE-1:0]  out_byteen_q, out_byteen_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic [OTAG_W-1:0]     out_tag_q, out_tag_d;

  logic [PEND_W-1:0]     pending_q, pending_d;
  logic                  busy_q, busy_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0]      rsp_idx_q, rsp_idx_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;

  // Reads are hidden from the arbiter at the pending limit so writes still win.
  assign pend_full   = (pending_q == PEND_W'(MAX_PENDING));
  assign stage_ready = !out_valid_q || out_req_ready;
  assign arb_req     = in_req_valid & (in_req_rw | {NUM_REQS{!pend_full}});

  vx_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (arb_req),
    .en          (reset && stage_ready),
    .grant_c     (grant),
    .grant_idx_c (gidx),
    .grant_vld_c (gvld)
  );

  assign in_req_ready = grant;
  assign pend_inc     = gvld && !in_req_rw[gidx];
  // The response register is empty or drains into its channel this cycle.
  assign out_rsp_ready = reset && (!rsp_valid_q || in_rsp_ready[rsp_idx_q]);
  assign pend_dec      = out_rsp_valid && out_rsp_ready;

  // Next state for the output stage, the pending counter and the response register.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_rw_d     = out_rw_q;
    out_addr_d   = out_addr_q;
    out_byteen_d = out_byteen_q;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    pending_d    = pending_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_idx_d    = rsp_idx_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_data_d   = rsp_data_q;

    if (out_valid_q && out_req_ready) out_valid_d = 1'b0;
    if (gvld) begin
      out_valid_d  = 1'b1;
      out_rw_d     = in_req_rw[gidx];
      out_addr_d   = in_req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
      out_byteen_d = in_req_byteen[gidx*DATA_SIZE +: DATA_SIZE];
      out_data_d   = in_req_data[gidx*DATA_W +: DATA_W];
      out_tag_d    = {in_req_tag[gidx*TAG_WIDTH +: TAG_WIDTH], gidx};
    end

    if (pend_inc && !pend_dec)      pending_d = pending_q + PEND_W'(1);
    else if (pend_dec && !pend_inc) pending_d = pending_q - PEND_W'(1);

    if (rsp_valid_q && in_rsp_ready[rsp_idx_q]) rsp_valid_d = 1'b0;
    if (pend_dec) begin
      rsp_valid_d = 1'b1;
      rsp_idx_d   = out_rsp_tag[IDX_W-1:0];
      rsp_tag_d   = out_rsp_tag[OTAG_W-1:IDX_W];
      rsp_data_d  = out_rsp_data;
    end

    busy_d = (pending_d != '0) || out_valid_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_rw_q     <= 1'b0;
      out_addr_q   <= '0;
      out_byteen_q <= '0;
      out_data_q   <= '0;
      out_tag_q    <= '0;
      pending_q    <= '0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_idx_q    <= '0;
      rsp_tag_q    <= '0;
      rsp_data_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_rw_q     <= out_rw_d;
      out_addr_q   <= out_addr_d;
      out_byteen_q <= out_byteen_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_idx_q    <= rsp_idx_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign out_req_valid  = out_valid_q;
  assign out_req_rw     = out_rw_q;
  assign out_req_addr   = out_addr_q;
  assign out_req_byteen = out_byteen_q;
  assign out_req_data   = out_data_q;
  assign out_req_tag    = out_tag_q;
  assign pending_count  = pending_q;
  assign busy           = busy_q;
  assign in_rsp_valid   = rsp_valid_q ? (NUM_REQS'(1) << rsp_idx_q) : '0;
  assign in_rsp_data    = {NUM_REQS{rsp_data_q}};
  assign in_rsp_tag     = {NUM_REQS{rsp_tag_q}};

  // A response with nothing outstanding, or aimed at a nonexistent channel, is a protocol error.
  a_rsp_has_pending: assert property (@(posedge clk) disable iff (!reset)
    (out_rsp_valid && out_rsp_ready) |-> (pending_q != '0));
  a_rsp_idx_range: assert property (@(posedge clk) disable iff (!reset)
    out_rsp_valid |-> (32'(out_rsp_tag[IDX_W-1:0]) < NUM_REQS));

endmodule

// File: tb/tb_vx_dcache_req_arb.sv
// Bench for vx_dcache_req_arb. The main process drives requests and ready
// signals. A second process plays the memory and checks every output against
// a transaction-level model of the arbiter.
module tb_vx_dcache_req_arb;
  import vx_dcache_req_arb_pkg::*;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TW   = 8;
  localparam int MAXP = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_req_valid, in_req_rw, in_req_ready;
  logic [N*AW-1:0] in_req_addr;
  logic [N*4-1:0]  in_req_byteen;
  logic [N*DW-1:0] in_req_data;
  logic [N*TW-1:0] in_req_tag;
  logic [N-1:0]    in_rsp_valid, in_rsp_ready;
  logic [N*DW-1:0] in_rsp_data;
  logic [N*TW-1:0] in_rsp_tag;
  logic            out_req_valid, out_req_rw, out_req_ready;
  logic [AW-1:0]   out_req_addr;
  logic [3:0]      out_req_byteen;
  logic [DW-1:0]   out_req_data;
  logic [TW+1:0]   out_req_tag;
  logic            out_rsp_valid, out_rsp_ready;
  logic [DW-1:0]   out_rsp_data;
  logic [TW+1:0]   out_rsp_tag;
  logic [4:0]      pending_count;
  logic            busy;

  vx_dcache_req_arb dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
    .in_req_byteen(in_req_byteen), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
    .in_rsp_ready(in_rsp_ready),
    .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
    .out_req_byteen(out_req_byteen), .out_req_data(out_req_data), .out_req_tag(out_req_tag),
    .out_req_ready(out_req_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
    .out_rsp_ready(out_rsp_ready),
    .pending_count(pending_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] data;
    logic [TW+1:0] tag;
  } req_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        rsp_en = 1'b0;

  // Model state, owned by the memory/monitor process.
  req_t          req_q[$];
  logic [TW+1:0] mem_q[$];
  int            m_next, m_pend, g;
  logic          m_stage_full, m_rsp_full, rsp_fired, exp_ordy;
  logic [1:0]    m_rsp_idx;
  logic [TW-1:0] m_rsp_tag;
  logic [DW-1:0] m_rsp_data;
  logic [N-1:0]  exp_grant;
  req_t          it;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    req_q.delete();
    mem_q.delete();
    m_next = 0; m_pend = 0; m_stage_full = 1'b0; m_rsp_full = 1'b0;
    rsp_fired = 1'b0; out_rsp_valid = 1'b0;
  endtask

  // Memory model + scoreboard: drive responses after the edge, check at the falling edge.
  initial begin
    out_rsp_valid = 1'b0; out_rsp_tag = '0; out_rsp_data = '0;
    m_rsp_idx = '0; m_rsp_tag = '0; m_rsp_data = '0;
    model_clear();
    forever begin
      @(posedge clk); #1;
      if (rsp_fired) begin out_rsp_valid = 1'b0; rsp_fired = 1'b0; end
      if (reset && rsp_en && !out_rsp_valid && mem_q.size() > 0 && $urandom_range(0, 99) < 60) begin
        out_rsp_tag   = mem_q.pop_front();
        out_rsp_data  = $urandom;
        out_rsp_valid = 1'b1;
      end
      @(negedge clk);
      if (!reset) begin
        chk("rst_out_req_valid", 128'(out_req_valid), 128'(0));
        chk("rst_in_req_ready", 128'(in_req_ready), 128'(0));
        chk("rst_in_rsp_valid", 128'(in_rsp_valid), 128'(0));
        chk("rst_out_rsp_ready", 128'(out_rsp_ready), 128'(0));
        chk("rst_pending", 128'(pending_count), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        model_clear();
      end else begin
        chk("pending_count", 128'(pending_count), 128'(m_pend));
        chk("busy", 128'(busy), 128'((m_pend != 0) || m_stage_full));

        // Expected grant: first eligible channel after the last granted one.
        exp_grant = '0; g = -1;
        if (!m_stage_full || out_req_ready)
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_next + k) % N;
            if (g < 0 && in_req_valid[c] && (in_req_rw[c] || m_pend < MAXP)) g = c;
          end
        if (g >= 0) exp_grant[g] = 1'b1;
        chk("in_req_ready", 128'(in_req_ready), 128'(exp_grant));

        chk("out_req_valid", 128'(out_req_valid), 128'(m_stage_full));
        if (m_stage_full) begin
          chk("out_req_rw", 128'(out_req_rw), 128'(req_q[0].rw));
          chk("out_req_addr", 128'(out_req_addr), 128'(req_q[0].addr));
          chk("out_req_byteen", 128'(out_req_byteen), 128'(req_q[0].be));
          chk("out_req_data", 128'(out_req_data), 128'(req_q[0].data));
          chk("out_req_tag", 128'(out_req_tag), 128'(req_q[0].tag));
          if (out_req_ready) begin
            it = req_q.pop_front();
            if (!it.rw) mem_q.push_back(it.tag);
            m_stage_full = 1'b0;
          end
        end
        if (g >= 0) begin
          it.rw   = in_req_rw[g];
          it.addr = in_req_addr[g*AW +: AW];
          it.be   = in_req_byteen[g*4 +: 4];
          it.data = in_req_data[g*DW +: DW];
          it.tag  = pack_tag(in_req_tag[g*TW +: TW], 2'(g));
          req_q.push_back(it);
          m_stage_full = 1'b1;
          m_next = (g + 1) % N;
          if (!it.rw) m_pend++;
        end

        exp_ordy = !m_rsp_full || in_rsp_ready[m_rsp_idx];
        chk("out_rsp_ready", 128'(out_rsp_ready), 128'(exp_ordy));
        chk("in_rsp_valid", 128'(in_rsp_valid), 128'(m_rsp_full ? (4'b0001 << m_rsp_idx) : 4'b0000));
        if (m_rsp_full) begin
          chk("in_rsp_tag", 128'(in_rsp_tag), 128'({N{m_rsp_tag}}));
          chk("in_rsp_data", in_rsp_data, {N{m_rsp_data}});
          if (in_rsp_ready[m_rsp_idx]) m_rsp_full = 1'b0;
        end
        if (out_rsp_valid && exp_ordy) begin
          m_rsp_full = 1'b1;
          m_rsp_idx  = tag_idx(out_rsp_tag);
          m_rsp_tag  = tag_src(out_rsp_tag);
          m_rsp_data = out_rsp_data;
          m_pend--;
          rsp_fired  = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic [N-1:0] v, input logic [N-1:0] rw);
    in_req_valid = v;
    in_req_rw    = rw;
    for (int k = 0; k < N; k++) begin
      in_req_addr[k*AW +: AW]  = $urandom;
      in_req_byteen[k*4 +: 4]  = 4'($urandom);
      in_req_data[k*DW +: DW]  = $urandom;
      in_req_tag[k*TW +: TW]   = 8'($urandom);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_req_valid = '0; in_req_rw = '0; in_req_addr = '0; in_req_byteen = '0;
    in_req_data = '0; in_req_tag = '0; in_rsp_ready = '1; out_req_ready = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    cyc(); reset = 1'b1;

    // Single read on channel 2, tag 0x5A, addr 0x100.
    rsp_en = 1'b1;
    set_req(4'b0100, 4'b0000);
    in_req_addr[2*AW +: AW] = 32'h100;
    in_req_tag[2*TW +: TW]  = 8'h5A;
    cyc();
    in_req_valid = '0;
    repeat (8) cyc();

    // All channels valid: rotating grants, one per cycle.
    repeat (8) begin set_req(4'hF, 4'($urandom)); cyc(); end
    // Output stalled: stage holds, no grants.
    out_req_ready = 1'b0;
    repeat (3) begin set_req(4'hF, 4'($urandom)); cyc(); end
    out_req_ready = 1'b1;
    in_req_valid = '0;
    repeat (20) cyc();

    // Fill to the pending limit, then a write on channel 0 must still pass.
    rsp_en = 1'b0;
    repeat (22) begin set_req(4'hF, 4'h0); cyc(); end
    repeat (3) begin set_req(4'hF, 4'b0001); cyc(); end
    rsp_en = 1'b1;
    repeat (6) begin set_req(4'hF, 4'h0); cyc(); end
    in_req_valid = '0;
    repeat (40) cyc();

    // Random traffic with random backpressure on both sides.
    repeat (400) begin
      set_req(4'($urandom), 4'($urandom));
      out_req_ready = ($urandom_range(0, 3) != 0);
      in_rsp_ready  = 4'($urandom);
      cyc();
    end
    in_req_valid = '0; out_req_ready = 1'b1; in_rsp_ready = '1;
    repeat (30) cyc();

    // Channel 1 refuses responses while channels 1 and 3 read.
    in_rsp_ready = 4'b1101;
    repeat (4) begin set_req(4'b1010, 4'h0); cyc(); end
    in_req_valid = '0;
    repeat (8) cyc();
    in_rsp_ready = '1;
    repeat (12) cyc();

    // Reset in the middle of a read burst, then check the pointer restarts at 0.
    rsp_en = 1'b0;
    repeat (4) begin set_req(4'hF, 4'h0); cyc(); end
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    rsp_en = 1'b1;
    repeat (6) begin set_req(4'hF, 4'($urandom)); cyc(); end

    in_req_valid = '0; out_req_ready = 1'b1; in_rsp_ready = '1;
    repeat (60) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
